// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED pattern controller: channel modes and the
// configuration handshake states.
package led_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    typedef enum logic {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: selects the raw drive level from the channel's active mode
// and the shared blink / PWM counters. Purely combinational.
module led_pwm_channel
    import led_ctrl_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [PWM_W-1:0]  duty,
    input  logic              blink,
    input  logic [PWM_W-1:0]  pwm_cnt,
    output logic              raw
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        raw = 1'b0;
        case (led_mode_t'(mode))
            LED_OFF:   raw = 1'b0;
            LED_ON:    raw = 1'b1;
            LED_BLINK: raw = blink;
            LED_PWM:   raw = (pwm_cnt < duty);
            default:   raw = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// N-channel LED pattern generator with a valid/ready configuration port.
// Writes land in a shadow entry and are applied only on a PWM period wrap.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS   = 4,
    parameter int LOG2DELAY  = 25,
    parameter int PWM_W      = 8,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int CHAN_W    = $clog2(NUM_LEDS) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [PWM_W-1:0]    cfg_duty,
    output logic                cfg_err,
    output logic                commit_o,
    output logic [NUM_LEDS-1:0] led_o
);

    logic [LOG2DELAY-1:0] presc;
    logic [NUM_LEDS-1:0]  blink_cnt;
    logic [PWM_W-1:0]     pwm_cnt;
    logic                 tick;
    logic                 pwm_wrap;

    led_mode_t            act_mode [NUM_LEDS];
    logic [PWM_W-1:0]     act_duty [NUM_LEDS];

    cfg_state_t           state;
    logic [CHAN_W-1:0]    sh_chan;
    led_mode_t            sh_mode;
    logic [PWM_W-1:0]     sh_duty;

    logic [NUM_LEDS-1:0]  raw;
    logic                 accept;
    logic                 chan_ok;

    assign tick     = &presc;
    assign pwm_wrap = &pwm_cnt;
    assign accept   = cfg_valid && cfg_ready;
    assign chan_ok  = (cfg_chan < CHAN_W'(NUM_LEDS));

    // Blink counter wraps naturally at all-ones; bit i toggles every 2**i ticks.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            presc     <= '0;
            blink_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc   <= presc + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            if (tick) begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CFG_IDLE;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            commit_o  <= 1'b0;
            sh_chan   <= '0;
            sh_mode   <= LED_OFF;
            sh_duty   <= '0;
            // NOTE: the active table is a handful of flops, not a RAM, so it is reset to OFF with everything else.
            for (int i = 0; i < NUM_LEDS; i++) begin
                act_mode[i] <= LED_OFF;
                act_duty[i] <= '0;
            end
        end else begin
            cfg_err  <= accept && !chan_ok;
            commit_o <= 1'b0;
            case (state)
                CFG_IDLE: begin
                    if (accept && chan_ok) begin
                        sh_chan   <= cfg_chan;
                        sh_mode   <= led_mode_t'(cfg_mode);
                        sh_duty   <= cfg_duty;
                        cfg_ready <= 1'b0;
                        state     <= CFG_PENDING;
                    end
                end
                CFG_PENDING: begin
                    // Applying only at the period wrap keeps PWM outputs glitch-free.
                    if (pwm_wrap) begin
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            if (sh_chan == CHAN_W'(i)) begin
                                act_mode[i] <= sh_mode;
                                act_duty[i] <= sh_duty;
                            end
                        end
                        commit_o  <= 1'b1;
                        cfg_ready <= 1'b1;
                        state     <= CFG_IDLE;
                    end
                end
                default: state <= CFG_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_pwm_channel #(
            .PWM_W (PWM_W)
        ) u_chan (
            .mode    (act_mode[g]),
            .duty    (act_duty[g]),
            .blink   (blink_cnt[g]),
            .pwm_cnt (pwm_cnt),
            .raw     (raw[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_o <= {NUM_LEDS{ACTIVE_LOW}};
        end else begin
            led_o <= raw ^ {NUM_LEDS{ACTIVE_LOW}};
        end
    end

endmodule
